// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// -----------
// Issue/hazard controller between decode and execute.
//
// Each cycle it decides whether the decoded instruction enters execute
// (ow_issue) or a bubble is inserted. A per-register scoreboard counts
// in-flight GP writes. A separate counter does the same for the flags.
// Entries are raised when an instruction issues and lowered when it
// retires at writeback. A drain request stops issue until every
// in-flight write has retired, then pulses ow_drained for one cycle.
//
// Ports
//   iw_clk, iw_rst_n       clock, synchronous active-low reset
//   iw_id_*                decode-stage instruction descriptor
//   iw_flush               kill the decode-stage instruction this cycle
//   iw_wb_*                writeback retirement descriptor
//   iw_drain_req           level request to drain the pipeline
//   ow_issue / ow_stall / ow_bubble   per-cycle issue decision
//   ow_drained             one-cycle pulse when a drain completes
//   ow_busy_mask / ow_fl_busy         scoreboard occupancy (registered)
//   ow_err                 sticky writeback-underflow flag
//   ow_stall_cnt           saturating count of stall cycles
module hazard_ctrl #(
    parameter int NUM_GP  = 16,
    parameter int GP_AW   = 4,
    parameter int CNT_W   = 2,
    parameter int STALL_W = 16
) (
    input  logic               iw_clk,
    input  logic               iw_rst_n,
    input  logic               iw_id_valid,
    input  logic [GP_AW-1:0]   iw_id_src_gp,
    input  logic               iw_id_src_rd,
    input  logic [GP_AW-1:0]   iw_id_tgt_gp,
    input  logic               iw_id_tgt_rd,
    input  logic               iw_id_tgt_wr,
    input  logic               iw_id_fl_rd,
    input  logic               iw_id_fl_wr,
    input  logic               iw_flush,
    input  logic               iw_wb_valid,
    input  logic [GP_AW-1:0]   iw_wb_tgt_gp,
    input  logic               iw_wb_gp_wr,
    input  logic               iw_wb_fl_wr,
    input  logic               iw_drain_req,
    output logic               ow_issue,
    output logic               ow_stall,
    output logic               ow_bubble,
    output logic               ow_drained,
    output logic [NUM_GP-1:0]  ow_busy_mask,
    output logic               ow_fl_busy,
    output logic               ow_err,
    output logic [STALL_W-1:0] ow_stall_cnt
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t               state_reg, state_next;
    logic [CNT_W-1:0]     fl_cnt_reg, fl_cnt_next;
    logic                 fl_uflow;
    logic                 err_reg, err_next;
    logic [STALL_W-1:0]   stall_cnt_reg, stall_cnt_next;

    // Per-register views of the scoreboard, one bit per GP register.
    logic [NUM_GP-1:0]    gp_busy;       // registered count != 0
    logic [NUM_GP-1:0]    gp_full;       // registered count == MAX
    logic [NUM_GP-1:0]    gp_next_busy;  // next-state count != 0
    logic [NUM_GP-1:0]    gp_uflow;      // retire against an empty entry

    logic                 hazard;
    logic                 issue_w;
    logic                 stall_w;

    // ------------------------------------------------------------------
    // Issue decision. Uses registered counts only, so a writeback in the
    // same cycle does not release a dependent instruction until the next
    // cycle. Gated by reset so outputs stay quiet while reset is held.
    // ------------------------------------------------------------------
    always_comb begin
        hazard = (iw_id_src_rd && gp_busy[iw_id_src_gp])
              || (iw_id_tgt_rd && gp_busy[iw_id_tgt_gp])
              || (iw_id_fl_rd  && (fl_cnt_reg != '0))
              || (iw_id_tgt_wr && gp_full[iw_id_tgt_gp])
              || (iw_id_fl_wr  && (fl_cnt_reg == CNT_MAX));
    end

    assign issue_w = iw_rst_n && iw_id_valid && !iw_flush
                  && (state_reg == ST_RUN) && !hazard;
    assign stall_w = iw_rst_n && iw_id_valid && !iw_flush && !issue_w;

    // ------------------------------------------------------------------
    // GP scoreboard: one small counter per register. An increment and a
    // decrement hitting the same register in one cycle cancel out.
    // Overflow cannot happen because a full entry blocks issue.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_GP; gi++) begin : g_sb
            logic [CNT_W-1:0] cnt_reg, cnt_next;
            logic             inc, dec, uflow;

            assign inc = issue_w && iw_id_tgt_wr
                      && (iw_id_tgt_gp == GP_AW'(gi));
            assign dec = iw_wb_valid && iw_wb_gp_wr
                      && (iw_wb_tgt_gp == GP_AW'(gi));

            always_comb begin
                cnt_next = cnt_reg;
                uflow    = 1'b0;
                if (inc && !dec) begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end else if (dec && !inc) begin
                    if (cnt_reg == '0) begin
                        uflow = 1'b1;
                    end else begin
                        cnt_next = cnt_reg - CNT_W'(1);
                    end
                end
            end

            always_ff @(posedge iw_clk) begin
                if (!iw_rst_n) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_next;
                end
            end

            assign gp_busy[gi]      = (cnt_reg != '0);
            assign gp_full[gi]      = (cnt_reg == CNT_MAX);
            assign gp_next_busy[gi] = (cnt_next != '0);
            assign gp_uflow[gi]     = uflow;
        end
    endgenerate

    // Flags scoreboard: same rules as a single GP entry.
    always_comb begin
        logic fl_inc, fl_dec;
        fl_inc      = issue_w && iw_id_fl_wr;
        fl_dec      = iw_wb_valid && iw_wb_fl_wr;
        fl_cnt_next = fl_cnt_reg;
        fl_uflow    = 1'b0;
        if (fl_inc && !fl_dec) begin
            fl_cnt_next = fl_cnt_reg + CNT_W'(1);
        end else if (fl_dec && !fl_inc) begin
            if (fl_cnt_reg == '0) begin
                fl_uflow = 1'b1;
            end else begin
                fl_cnt_next = fl_cnt_reg - CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Drain FSM. DRAIN looks at next-state counts so the final retirement
    // and the move to DONE happen on the same edge.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_RUN: begin
                if (iw_drain_req) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((gp_next_busy == '0) && (fl_cnt_next == '0)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_RUN;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    always_comb begin
        err_next       = err_reg || (gp_uflow != '0) || fl_uflow;
        stall_cnt_next = stall_cnt_reg;
        if (stall_w && (stall_cnt_reg != '1)) begin
            stall_cnt_next = stall_cnt_reg + STALL_W'(1);
        end
    end

    always_ff @(posedge iw_clk) begin
        if (!iw_rst_n) begin
            state_reg     <= ST_RUN;
            fl_cnt_reg    <= '0;
            err_reg       <= 1'b0;
            stall_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            fl_cnt_reg    <= fl_cnt_next;
            err_reg       <= err_next;
            stall_cnt_reg <= stall_cnt_next;
        end
    end

    assign ow_issue     = issue_w;
    assign ow_stall     = stall_w;
    assign ow_bubble    = !issue_w;
    assign ow_drained   = (state_reg == ST_DONE);
    assign ow_busy_mask = gp_busy;
    assign ow_fl_busy   = (fl_cnt_reg != '0);
    assign ow_err       = err_reg;
    assign ow_stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl
// --------------
// Directed, table-driven bench for hazard_ctrl. Each table row is one
// clock cycle: inputs applied just after the rising edge, outputs
// compared on the falling edge. Hand-written sequences afterwards cover
// stall-counter saturation and reset in the middle of a drain.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [3:0]  id_src_gp;
    logic        id_src_rd;
    logic [3:0]  id_tgt_gp;
    logic        id_tgt_rd;
    logic        id_tgt_wr;
    logic        id_fl_rd;
    logic        id_fl_wr;
    logic        flush;
    logic        wb_valid;
    logic [3:0]  wb_tgt_gp;
    logic        wb_gp_wr;
    logic        wb_fl_wr;
    logic        drain_req;
    logic        issue;
    logic        stall;
    logic        bubble;
    logic        drained;
    logic [15:0] busy_mask;
    logic        fl_busy;
    logic        err;
    logic [15:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .NUM_GP (16),
        .GP_AW  (4),
        .CNT_W  (2),
        .STALL_W(16)
    ) dut (
        .iw_clk       (clk),
        .iw_rst_n     (rst_n),
        .iw_id_valid  (id_valid),
        .iw_id_src_gp (id_src_gp),
        .iw_id_src_rd (id_src_rd),
        .iw_id_tgt_gp (id_tgt_gp),
        .iw_id_tgt_rd (id_tgt_rd),
        .iw_id_tgt_wr (id_tgt_wr),
        .iw_id_fl_rd  (id_fl_rd),
        .iw_id_fl_wr  (id_fl_wr),
        .iw_flush     (flush),
        .iw_wb_valid  (wb_valid),
        .iw_wb_tgt_gp (wb_tgt_gp),
        .iw_wb_gp_wr  (wb_gp_wr),
        .iw_wb_fl_wr  (wb_fl_wr),
        .iw_drain_req (drain_req),
        .ow_issue     (issue),
        .ow_stall     (stall),
        .ow_bubble    (bubble),
        .ow_drained   (drained),
        .ow_busy_mask (busy_mask),
        .ow_fl_busy   (fl_busy),
        .ow_err       (err),
        .ow_stall_cnt (stall_cnt)
    );

    typedef struct {
        logic        rst_n;
        logic        valid;
        logic [3:0]  src;
        logic        srd;
        logic [3:0]  tgt;
        logic        trd;
        logic        twr;
        logic        frd;
        logic        fwr;
        logic        fls;
        logic        wbg;
        logic [3:0]  wbt;
        logic        wbf;
        logic        drn;
        logic        e_iss;
        logic        e_stl;
        logic        e_drd;
        logic [15:0] e_busy;
        logic        e_flb;
        logic        e_err;
        logic [15:0] e_cnt;
    } vec_t;

    function automatic vec_t V(
        input int rst, val, src, srd, tgt, trd, twr, frd, fwr, fls,
        input int wbg, wbt, wbf, drn,
        input int iss, stl, drd, busy, flb, er, cnt
    );
        vec_t v;
        v.rst_n  = rst[0];
        v.valid  = val[0];
        v.src    = src[3:0];
        v.srd    = srd[0];
        v.tgt    = tgt[3:0];
        v.trd    = trd[0];
        v.twr    = twr[0];
        v.frd    = frd[0];
        v.fwr    = fwr[0];
        v.fls    = fls[0];
        v.wbg    = wbg[0];
        v.wbt    = wbt[3:0];
        v.wbf    = wbf[0];
        v.drn    = drn[0];
        v.e_iss  = iss[0];
        v.e_stl  = stl[0];
        v.e_drd  = drd[0];
        v.e_busy = busy[15:0];
        v.e_flb  = flb[0];
        v.e_err  = er[0];
        v.e_cnt  = cnt[15:0];
        return v;
    endfunction

    task automatic apply(input vec_t v);
        rst_n     = v.rst_n;
        id_valid  = v.valid;
        id_src_gp = v.src;
        id_src_rd = v.srd;
        id_tgt_gp = v.tgt;
        id_tgt_rd = v.trd;
        id_tgt_wr = v.twr;
        id_fl_rd  = v.frd;
        id_fl_wr  = v.fwr;
        flush     = v.fls;
        wb_valid  = v.wbg | v.wbf;
        wb_tgt_gp = v.wbt;
        wb_gp_wr  = v.wbg;
        wb_fl_wr  = v.wbf;
        drain_req = v.drn;
    endtask

    task automatic chk(input string tag, input string nm,
                       input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s %s: got %0h want %0h", tag, nm, act, exp);
        end
    endtask

    // One cycle: drive, compare on the falling edge, advance past the
    // next rising edge.
    task automatic run_vec(input vec_t v, input string tag);
        apply(v);
        @(negedge clk);
        chk(tag, "issue",     32'(issue),     32'(v.e_iss));
        chk(tag, "stall",     32'(stall),     32'(v.e_stl));
        chk(tag, "bubble",    32'(bubble),    32'(!v.e_iss));
        chk(tag, "drained",   32'(drained),   32'(v.e_drd));
        chk(tag, "busy_mask", 32'(busy_mask), 32'(v.e_busy));
        chk(tag, "fl_busy",   32'(fl_busy),   32'(v.e_flb));
        chk(tag, "err",       32'(err),       32'(v.e_err));
        chk(tag, "stall_cnt", 32'(stall_cnt), 32'(v.e_cnt));
        $display("%s: iss=%0b stl=%0b bub=%0b drd=%0b busy=%04h flb=%0b err=%0b scnt=%04h",
                 tag, issue, stall, bubble, drained, busy_mask, fl_busy, err, stall_cnt);
        @(posedge clk);
        #1;
    endtask

    localparam int NVEC = 43;
    vec_t tbl [NVEC];

    initial begin
        // cols: rst val src srd tgt trd twr frd fwr fls wbg wbt wbf drn | iss stl drd busy flb err cnt
        // reset held
        tbl[0]  = V(0,0,0,0,0,0,0,0,0,0, 0,0,0,0, 0,0,0,'h0000,0,0,0);
        // RAW on r3, released the cycle after writeback
        tbl[1]  = V(1,1,0,0,3,0,1,0,0,0, 0,0,0,0, 1,0,0,'h0000,0,0,0);
        tbl[2]  = V(1,1,3,1,0,0,0,0,0,0, 0,0,0,0, 0,1,0,'h0008,0,0,0);
        tbl[3]  = V(1,1,3,1,0,0,0,0,0,0, 0,0,0,0, 0,1,0,'h0008,0,0,1);
        tbl[4]  = V(1,1,3,1,0,0,0,0,0,0, 1,3,0,0, 0,1,0,'h0008,0,0,2);
        tbl[5]  = V(1,1,3,1,0,0,0,0,0,0, 0,0,0,0, 1,0,0,'h0000,0,0,3);
        // r5 fills to MAX, fourth write waits for one retirement
        tbl[6]  = V(1,1,0,0,5,0,1,0,0,0, 0,0,0,0, 1,0,0,'h0000,0,0,3);
        tbl[7]  = V(1,1,0,0,5,0,1,0,0,0, 0,0,0,0, 1,0,0,'h0020,0,0,3);
        tbl[8]  = V(1,1,0,0,5,0,1,0,0,0, 0,0,0,0, 1,0,0,'h0020,0,0,3);
        tbl[9]  = V(1,1,0,0,5,0,1,0,0,0, 0,0,0,0, 0,1,0,'h0020,0,0,3);
        tbl[10] = V(1,1,0,0,5,0,1,0,0,0, 1,5,0,0, 0,1,0,'h0020,0,0,4);
        tbl[11] = V(1,1,0,0,5,0,1,0,0,0, 0,0,0,0, 1,0,0,'h0020,0,0,5);
        tbl[12] = V(1,0,0,0,0,0,0,0,0,0, 1,5,0,0, 0,0,0,'h0020,0,0,5);
        tbl[13] = V(1,0,0,0,0,0,0,0,0,0, 1,5,0,0, 0,0,0,'h0020,0,0,5);
        tbl[14] = V(1,0,0,0,0,0,0,0,0,0, 1,5,0,0, 0,0,0,'h0020,0,0,5);
        // r7: simultaneous issue+wb, then clean retire, then underflow
        tbl[15] = V(1,1,0,0,7,0,1,0,0,0, 0,0,0,0, 1,0,0,'h0000,0,0,5);
        tbl[16] = V(1,1,0,0,7,0,1,0,0,0, 1,7,0,0, 1,0,0,'h0080,0,0,5);
        tbl[17] = V(1,0,0,0,0,0,0,0,0,0, 1,7,0,0, 0,0,0,'h0080,0,0,5);
        tbl[18] = V(1,0,0,0,0,0,0,0,0,0, 1,7,0,0, 0,0,0,'h0000,0,0,5);
        tbl[19] = V(1,0,0,0,0,0,0,0,0,0, 0,0,0,0, 0,0,0,'h0000,0,1,5);
        tbl[20] = V(1,0,0,0,0,0,0,0,0,0, 0,0,0,0, 0,0,0,'h0000,0,1,5);
        // flags producer then consumer
        tbl[21] = V(1,1,0,0,0,0,0,0,1,0, 0,0,0,0, 1,0,0,'h0000,0,1,5);
        tbl[22] = V(1,1,0,0,0,0,0,1,0,0, 0,0,0,0, 0,1,0,'h0000,1,1,5);
        tbl[23] = V(1,1,0,0,0,0,0,1,0,0, 0,0,1,0, 0,1,0,'h0000,1,1,6);
        tbl[24] = V(1,1,0,0,0,0,0,1,0,0, 0,0,0,0, 1,0,0,'h0000,0,1,7);
        // flush: no issue, no stall
        tbl[25] = V(1,1,3,1,0,0,0,0,0,1, 0,0,0,0, 0,0,0,'h0000,0,1,7);
        // writes to r1, r2; tgt_rd hazard; drain
        tbl[26] = V(1,1,0,0,1,0,1,0,0,0, 0,0,0,0, 1,0,0,'h0000,0,1,7);
        tbl[27] = V(1,1,0,0,2,0,1,0,0,0, 0,0,0,0, 1,0,0,'h0002,0,1,7);
        tbl[28] = V(1,1,0,0,1,1,0,0,0,0, 0,0,0,0, 0,1,0,'h0006,0,1,7);
        tbl[29] = V(1,1,9,1,0,0,0,0,0,0, 0,0,0,1, 1,0,0,'h0006,0,1,8);
        tbl[30] = V(1,1,9,1,0,0,0,0,0,0, 0,0,0,1, 0,1,0,'h0006,0,1,8);
        tbl[31] = V(1,1,9,1,0,0,0,0,0,0, 1,1,0,1, 0,1,0,'h0006,0,1,9);
        tbl[32] = V(1,1,9,1,0,0,0,0,0,0, 1,2,0,1, 0,1,0,'h0004,0,1,10);
        tbl[33] = V(1,1,9,1,0,0,0,0,0,0, 0,0,0,0, 0,1,1,'h0000,0,1,11);
        tbl[34] = V(1,1,9,1,0,0,0,0,0,0, 0,0,0,0, 1,0,0,'h0000,0,1,12);
        // empty drain with request dropped during DRAIN
        tbl[35] = V(1,0,0,0,0,0,0,0,0,0, 0,0,0,1, 0,0,0,'h0000,0,1,12);
        tbl[36] = V(1,0,0,0,0,0,0,0,0,0, 0,0,0,0, 0,0,0,'h0000,0,1,12);
        tbl[37] = V(1,0,0,0,0,0,0,0,0,0, 0,0,0,0, 0,0,1,'h0000,0,1,12);
        tbl[38] = V(1,0,0,0,0,0,0,0,0,0, 0,0,0,0, 0,0,0,'h0000,0,1,12);
        // register 0 behaves like any other
        tbl[39] = V(1,1,0,0,0,0,1,0,0,0, 0,0,0,0, 1,0,0,'h0000,0,1,12);
        tbl[40] = V(1,1,0,1,0,0,0,0,0,0, 0,0,0,0, 0,1,0,'h0001,0,1,12);
        tbl[41] = V(1,0,0,0,0,0,0,0,0,0, 1,0,0,0, 0,0,0,'h0001,0,1,13);
        tbl[42] = V(1,1,0,1,0,0,0,0,0,0, 0,0,0,0, 1,0,0,'h0000,0,1,13);

        apply(V(0,0,0,0,0,0,0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0));
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < NVEC; i++) begin
            run_vec(tbl[i], $sformatf("vec%0d", i));
        end

        // Stall counter saturation: park a reader behind a write to r4.
        run_vec(V(1,1,0,0,4,0,1,0,0,0, 0,0,0,0, 1,0,0,'h0000,0,1,13), "sat_issue");
        apply(V(1,1,4,1,0,0,0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0));
        repeat (65541) @(posedge clk);
        #1;
        run_vec(V(1,1,4,1,0,0,0,0,0,0, 0,0,0,0, 0,1,0,'h0010,0,1,'hFFFF), "sat_hold");
        run_vec(V(1,1,4,1,0,0,0,0,0,0, 0,0,0,0, 0,1,0,'h0010,0,1,'hFFFF), "sat_stay");

        // Reset in the middle of a drain with r4 still pending.
        run_vec(V(1,1,9,1,0,0,0,0,0,0, 0,0,0,1, 1,0,0,'h0010,0,1,'hFFFF), "rd_enter");
        run_vec(V(1,1,9,1,0,0,0,0,0,0, 0,0,0,1, 0,1,0,'h0010,0,1,'hFFFF), "rd_drain");
        run_vec(V(0,0,0,0,0,0,0,0,0,0, 0,0,0,0, 0,0,0,'h0010,0,1,'hFFFF), "rd_reset");
        run_vec(V(1,1,4,1,0,0,0,0,0,0, 0,0,0,0, 1,0,0,'h0000,0,0,0),       "rd_after");
        run_vec(V(1,0,0,0,0,0,0,0,0,0, 0,0,0,0, 0,0,0,'h0000,0,0,0),       "rd_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
